// File: rtl/kcnt_pkg.sv
// Shared defaults for the programmable-modulus K counter.
// Optional lock detect is enabled by defining KCNT_LOCK_DETECT_EN.
package kcnt_pkg;

  localparam int KCNT_KW        = 8;
  localparam int KCNT_K_DEFAULT = 16;
  localparam int KCNT_LOCK_W    = 12;
  localparam int KCNT_MAX       = (2 ** KCNT_KW) - 1;

endpackage : kcnt_pkg

// File: rtl/kcnt_mod_counter.sv
// One modulo-K counter with a registered one-cycle wrap pulse.
// hit flags, combinationally, that the current advance is the wrapping one.
import kcnt_pkg::*;

module kcnt_mod_counter #(
  parameter int KW = KCNT_KW
) (
  input  logic          k_clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [KW-1:0] k,
  output logic          wrap,
  output logic          hit
);

  logic [KW-1:0] cnt;
  logic [KW-1:0] k_m1;

  // k is never zero, so k-1 never underflows
  assign k_m1 = k - KW'(1);
  assign hit  = inc && !clr && (cnt == k_m1);

  always_ff @(posedge k_clk) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (cnt == k_m1) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + KW'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule : kcnt_mod_counter

// File: rtl/k_counter_prog.sv
// Programmable-modulus up/down K counter for the ADPLL loop filter.
// Define KCNT_LOCK_DETECT_EN to build the lock-window detector; otherwise locked is 0.
import kcnt_pkg::*;

module k_counter_prog #(
  parameter int KW        = KCNT_KW,
  parameter int K_DEFAULT = KCNT_K_DEFAULT,
  parameter int LOCK_W    = KCNT_LOCK_W
) (
  input  logic          k_clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ud,
  input  logic          k_load,
  input  logic [KW-1:0] k_val,
  output logic          carry,
  output logic          borrow,
  output logic [KW-1:0] k_cur,
  output logic          locked
);

  logic [KW-1:0] k_reg;
  logic          up_hit;
  logic          dn_hit;

  // A zero modulus is rejected so k_reg stays >= 1
  always_ff @(posedge k_clk) begin
    if (rst) begin
      k_reg <= KW'(K_DEFAULT);
    end else if (k_load && (k_val != '0)) begin
      k_reg <= k_val;
    end
  end

  assign k_cur = k_reg;

  kcnt_mod_counter #(.KW(KW)) u_up (
    .k_clk (k_clk),
    .rst   (rst),
    .clr   (k_load),
    .inc   (en & ud),
    .k     (k_reg),
    .wrap  (carry),
    .hit   (up_hit)
  );

  kcnt_mod_counter #(.KW(KW)) u_dn (
    .k_clk (k_clk),
    .rst   (rst),
    .clr   (k_load),
    .inc   (en & ~ud),
    .k     (k_reg),
    .wrap  (borrow),
    .hit   (dn_hit)
  );

`ifdef KCNT_LOCK_DETECT_EN
  logic [LOCK_W-1:0] win;

  // Window restarts on the same edge the wrap pulse is registered
  always_ff @(posedge k_clk) begin
    if (rst) begin
      win <= '0;
    end else if (k_load || up_hit || dn_hit) begin
      win <= '0;
    end else if (en && !(&win)) begin
      win <= win + LOCK_W'(1);
    end
  end

  assign locked = &win;
`else
  logic unused_hits;
  assign unused_hits = up_hit ^ dn_hit;
  assign locked      = 1'b0;
`endif

endmodule : k_counter_prog

// File: tb/tb_k_counter_prog.sv
// Directed self-checking bench for k_counter_prog (lock checks build with KCNT_LOCK_DETECT_EN).
`timescale 1ns/1ps
module tb_k_counter_prog;

  localparam int KW = 8;

  logic          k_clk;
  logic          rst;
  logic          en;
  logic          ud;
  logic          k_load;
  logic [KW-1:0] k_val;
  logic          carry;
  logic          borrow;
  logic [KW-1:0] k_cur;
  logic          locked;

  int checks = 0;
  int errors = 0;

  k_counter_prog #(.KW(KW), .K_DEFAULT(16), .LOCK_W(4)) dut (
    .k_clk  (k_clk),
    .rst    (rst),
    .en     (en),
    .ud     (ud),
    .k_load (k_load),
    .k_val  (k_val),
    .carry  (carry),
    .borrow (borrow),
    .k_cur  (k_cur),
    .locked (locked)
  );

  initial begin
    k_clk = 1'b0;
    forever #5 k_clk = ~k_clk;
  end

  task automatic tick();
    @(posedge k_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ud = 1'b1; k_load = 1'b0; k_val = '0;
    tick();
    tick();
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%0b exp=0", carry); end
    checks++;
    if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%0b exp=0", borrow); end
    checks++;
    if (k_cur !== 8'd16) begin errors++; $display("FAIL reset_k_cur got=%0d exp=16", k_cur); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    rst = 1'b0;
  endtask

  task automatic test_up_k16();
    en = 1'b1; ud = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      tick();
      checks++;
      if (carry !== ((i % 16) == 0)) begin
        errors++; $display("FAIL up16_carry cyc=%0d got=%0b exp=%0b", i, carry, (i % 16) == 0);
      end
      checks++;
      if (borrow !== 1'b0) begin errors++; $display("FAIL up16_borrow cyc=%0d got=%0b exp=0", i, borrow); end
    end
  endtask

  task automatic test_load_mid_count();
    en = 1'b1; ud = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    k_load = 1'b1; k_val = 8'd5;
    tick();
    k_load = 1'b0;
    checks++;
    if (k_cur !== 8'd5) begin errors++; $display("FAIL load5_k_cur got=%0d exp=5", k_cur); end
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL load5_carry got=%0b exp=0", carry); end
    ud = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (borrow !== ((i % 5) == 0)) begin
        errors++; $display("FAIL dn5_borrow cyc=%0d got=%0b exp=%0b", i, borrow, (i % 5) == 0);
      end
      checks++;
      if (carry !== 1'b0) begin errors++; $display("FAIL dn5_carry cyc=%0d got=%0b exp=0", i, carry); end
    end
    // up counter was cleared by the load, so it wraps after exactly 5 more
    ud = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (carry !== (i == 5)) begin
        errors++; $display("FAIL up5_after_load cyc=%0d got=%0b exp=%0b", i, carry, i == 5);
      end
    end
  endtask

  task automatic test_k_zero_and_one();
    en = 1'b1; ud = 1'b1;
    k_load = 1'b1; k_val = 8'd0;
    tick();
    k_load = 1'b0;
    checks++;
    if (k_cur !== 8'd5) begin errors++; $display("FAIL kzero_k_cur got=%0d exp=5", k_cur); end
    checks++;
    if ((carry | borrow) !== 1'b0) begin errors++; $display("FAIL kzero_pulse got=%0b exp=0", carry | borrow); end
    k_load = 1'b1; k_val = 8'd1;
    tick();
    k_load = 1'b0;
    checks++;
    if (k_cur !== 8'd1) begin errors++; $display("FAIL kone_k_cur got=%0d exp=1", k_cur); end
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL kone_load_carry got=%0b exp=0", carry); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (carry !== 1'b1) begin errors++; $display("FAIL kone_carry cyc=%0d got=%0b exp=1", i, carry); end
    end
  endtask

  task automatic test_enable_and_reset();
    en = 1'b0; ud = 1'b1;
    k_load = 1'b1; k_val = 8'd4;
    tick();
    k_load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      en = (i % 2) == 1;
      tick();
      checks++;
      if (carry !== (i == 7)) begin
        errors++; $display("FAIL en_toggle_carry clk=%0d got=%0b exp=%0b", i, carry, i == 7);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL midrst_carry got=%0b exp=0", carry); end
    checks++;
    if (k_cur !== 8'd16) begin errors++; $display("FAIL midrst_k_cur got=%0d exp=16", k_cur); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (carry !== (i == 16)) begin
        errors++; $display("FAIL post_rst_carry cyc=%0d got=%0b exp=%0b", i, carry, i == 16);
      end
    end
  endtask

`ifdef KCNT_LOCK_DETECT_EN
  task automatic test_lock();
    en = 1'b1; ud = 1'b1;
    k_load = 1'b1; k_val = 8'd200;
    tick();
    k_load = 1'b0;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_after_load got=%0b exp=0", locked); end
    for (int i = 1; i <= 15; i++) begin
      ud = (i % 2) == 1;
      tick();
      checks++;
      if (locked !== (i == 15)) begin
        errors++; $display("FAIL lock_window cyc=%0d got=%0b exp=%0b", i, locked, i == 15);
      end
    end
    k_load = 1'b1; k_val = 8'd1;
    tick();
    k_load = 1'b0;
    ud = 1'b1;
    tick();
    checks++;
    if (carry !== 1'b1) begin errors++; $display("FAIL lock_forced_carry got=%0b exp=1", carry); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_cleared got=%0b exp=0", locked); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_k16();
    test_load_mid_count();
    test_k_zero_and_one();
    test_enable_and_reset();
`ifdef KCNT_LOCK_DETECT_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_k_counter_prog
